// File: rtl/spi_single_clk_peripheral_pkg.sv
// Shared constants and types for the single-clock SPI mode-0 peripheral.
package spi_single_clk_peripheral_pkg;

    localparam int BYTE_W_DEF  = 8;
    localparam int SYNC_STAGES = 2;

    // Synchronised level plus single-cycle edge strobes for one pad.
    typedef struct packed {
        logic lvl;
        logic rise;
        logic fall;
    } edge_t;

endpackage

// File: rtl/spi_single_clk_peripheral_if.sv
// Byte-side bus between the SPI peripheral and the command/register block.
interface spi_single_clk_peripheral_if #(
    parameter int BYTE_W = 8
);
    logic              spi_data_written;
    logic [BYTE_W-1:0] spi_data_to_send;
    logic [BYTE_W-1:0] spi_data_rx;
    logic              spi_dreq;
    logic              valid_read;

    modport master (
        output spi_data_written, spi_data_to_send,
        input  spi_data_rx, spi_dreq, valid_read
    );

    modport slave (
        input  spi_data_written, spi_data_to_send,
        output spi_data_rx, spi_dreq, valid_read
    );
endinterface

// File: rtl/spi_single_clk_peripheral_pad_sync.sv
// Multi-flop synchroniser for one asynchronous pad, with a history flop
// producing single-cycle rise/fall strobes.
module spi_pad_sync
    import spi_single_clk_peripheral_pkg::*;
#(
    parameter int   STAGES  = SYNC_STAGES,
    parameter logic RST_VAL = 1'b0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  pad,
    output edge_t sig
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], pad};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign sig.lvl  = sync_q[STAGES-1];
    assign sig.rise = sync_q[STAGES-1] & ~hist_q;
    assign sig.fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_single_clk_peripheral.sv
// SPI mode-0 peripheral, MSB first, oversampled entirely in the sys_clk domain,
// with a one-deep transmit holding register.
module spi_single_clk_peripheral
    import spi_single_clk_peripheral_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        csn_pad,
    input  logic                        sck_pad,
    input  logic                        mosi_pad,
    output logic                        miso_pad,
    spi_single_clk_peripheral_if.slave  host
);
    localparam int CNT_W = $clog2(BYTE_W + 1);

    edge_t csn_e, sck_e, mosi_e;

    spi_pad_sync #(.RST_VAL(1'b1)) u_csn_sync (
        .clk(sys_clk), .rst_n(sys_rst_n), .pad(csn_pad), .sig(csn_e));
    spi_pad_sync #(.RST_VAL(1'b0)) u_sck_sync (
        .clk(sys_clk), .rst_n(sys_rst_n), .pad(sck_pad), .sig(sck_e));
    spi_pad_sync #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(sys_clk), .rst_n(sys_rst_n), .pad(mosi_pad), .sig(mosi_e));

    logic unused_edges;
    assign unused_edges = ^{csn_e.rise, mosi_e.rise, mosi_e.fall};

    logic              cs_active;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] rx_sh_q, rx_sh_d;
    logic [BYTE_W-1:0] tx_sh_q, tx_sh_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic [BYTE_W-1:0] rx_q, rx_d;
    logic              dreq_q, dreq_d;
    logic              vr_q, vr_d;
    logic              skip_fall_q, skip_fall_d;

    assign cs_active = ~csn_e.lvl;

    always_comb begin
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        hold_d      = hold_q;
        rx_d        = rx_q;
        dreq_d      = 1'b0;
        vr_d        = vr_q;
        skip_fall_d = skip_fall_q;

        if (!cs_active) begin
            cnt_d       = '0;
            rx_sh_d     = '0;
            skip_fall_d = 1'b0;
        end else if (csn_e.fall) begin
            tx_sh_d     = hold_q;
            vr_d        = 1'b1;
            skip_fall_d = 1'b0;
        end else begin
            if (cnt_q == CNT_W'(BYTE_W)) begin
                rx_d        = rx_sh_q;
                dreq_d      = 1'b1;
                cnt_d       = '0;
                tx_sh_d     = hold_q;
                vr_d        = 1'b1;
                skip_fall_d = 1'b1;
            end else if (sck_e.rise) begin
                rx_sh_d = {rx_sh_q[BYTE_W-2:0], mosi_e.lvl};
                cnt_d   = cnt_q + CNT_W'(1);
            end
            // The fall right after a reload must keep the fresh MSB on MISO.
            if (sck_e.fall) begin
                if (skip_fall_q) skip_fall_d = 1'b0;
                else             tx_sh_d     = {tx_sh_q[BYTE_W-2:0], 1'b0};
            end
        end

        // Applied after any reload so the reload still takes the old byte.
        if (host.spi_data_written) begin
            hold_d = host.spi_data_to_send;
            vr_d   = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            rx_q        <= '0;
            dreq_q      <= 1'b0;
            vr_q        <= 1'b1;
            skip_fall_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            rx_q        <= rx_d;
            dreq_q      <= dreq_d;
            vr_q        <= vr_d;
            skip_fall_q <= skip_fall_d;
        end
    end

    assign miso_pad         = cs_active & tx_sh_q[BYTE_W-1];
    assign host.spi_data_rx = rx_q;
    assign host.spi_dreq    = dreq_q;
    assign host.valid_read  = vr_q;

endmodule

// File: tb/tb_spi_single_clk_peripheral.sv
// Directed bench: driver pushes expected bytes, monitors pop and compare.
module tb_spi_single_clk_peripheral;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic csn_pad = 1'b1;
    logic sck_pad = 1'b0;
    logic mosi_pad = 1'b0;
    logic miso_pad;
    logic drv_wr = 1'b0;
    logic tie_en = 1'b0;
    logic [7:0] drv_data = 8'h00;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rise_cyc = 0;
    logic miso_chk = 1'b0;

    logic [7:0] rx_exp[$];
    logic [7:0] miso_exp[$];

    spi_single_clk_peripheral_if #(.BYTE_W(8)) host ();

    assign host.spi_data_written = tie_en ? host.spi_dreq : drv_wr;
    assign host.spi_data_to_send = drv_data;

    spi_single_clk_peripheral #(.BYTE_W(8)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .csn_pad  (csn_pad),
        .sck_pad  (sck_pad),
        .mosi_pad (mosi_pad),
        .miso_pad (miso_pad),
        .host     (host.slave)
    );

    always #10 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Receive monitor: every dreq pulse must match the next expected byte.
    int dreq_w = 0;
    always @(negedge sys_clk) begin
        if (sys_rst_n && host.spi_dreq) begin
            if (dreq_w == 0) begin
                if (rx_exp.size() == 0) chk("dreq_unexpected", 32'd1, 32'd0);
                else                    chk("rx_byte", {24'd0, host.spi_data_rx}, {24'd0, rx_exp.pop_front()});
                chk("dreq_latency", cyc - rise_cyc, 32'd4);
            end
            dreq_w++;
        end else begin
            if (dreq_w != 0) chk("dreq_width", dreq_w, 32'd1);
            dreq_w = 0;
        end
    end

    // MISO monitor: sample on each SCK rise inside a frame.
    logic [7:0] miso_sh = 8'h00;
    int miso_n = 0;
    always @(posedge sck_pad or posedge csn_pad) begin
        if (csn_pad) begin
            miso_n = 0;
        end else if (sys_rst_n) begin
            miso_sh = {miso_sh[6:0], miso_pad};
            miso_n++;
            if (miso_n == 8) begin
                miso_n = 0;
                if (miso_chk) begin
                    if (miso_exp.size() == 0) chk("miso_unexpected", 32'd1, 32'd0);
                    else                      chk("miso_byte", {24'd0, miso_sh}, {24'd0, miso_exp.pop_front()});
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // 240 ns SCK: 6 sys_clk low, 6 high; MOSI changes while SCK is low.
    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi_pad = b[7-i];
            wait_cyc(6);
            sck_pad  = 1'b1;
            rise_cyc = cyc;
            wait_cyc(6);
            sck_pad  = 1'b0;
        end
    endtask

    task automatic host_write(input logic [7:0] d);
        @(negedge sys_clk);
        drv_data = d;
        drv_wr   = 1'b1;
        @(negedge sys_clk);
        drv_wr   = 1'b0;
    endtask

    task automatic cs_low();
        csn_pad = 1'b0;
        wait_cyc(8);
    endtask

    task automatic cs_high();
        wait_cyc(4);
        csn_pad = 1'b1;
        wait_cyc(8);
    endtask

    initial begin
        repeat (50000) @(posedge sys_clk);
        $display("FAIL watchdog: simulation did not finish within the cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state
        wait_cyc(3);
        chk("rst_dreq", host.spi_dreq, 0);
        chk("rst_valid_read", host.valid_read, 1);
        chk("rst_rx", host.spi_data_rx, 0);
        chk("rst_miso", miso_pad, 0);
        sys_rst_n = 1'b1;
        wait_cyc(4);
        chk("idle_miso", miso_pad, 0);
        chk("idle_valid_read", host.valid_read, 1);

        // 2: receive 0xA5
        cs_low();
        rx_exp.push_back(8'hA5);
        send_bits(8'hA5, 8);
        cs_high();

        // 3: transmit 0x3C from the holding register
        host_write(8'h3C);
        wait_cyc(1);
        chk("wr_valid_read", host.valid_read, 0);
        miso_chk = 1'b1;
        miso_exp.push_back(8'h3C);
        rx_exp.push_back(8'hC3);
        cs_low();
        chk("csfall_valid_read", host.valid_read, 1);
        chk("cs_miso_msb", miso_pad, 0);
        send_bits(8'hC3, 8);
        cs_high();
        miso_chk = 1'b0;

        // 4: dreq looped to write with 0x00, three back-to-back 0xFF bytes
        host_write(8'h00);
        drv_data = 8'h00;
        tie_en   = 1'b1;
        miso_chk = 1'b1;
        cs_low();
        for (int k = 0; k < 3; k++) begin
            rx_exp.push_back(8'hFF);
            miso_exp.push_back(8'h00);
            send_bits(8'hFF, 8);
        end
        cs_high();
        miso_chk = 1'b0;
        tie_en   = 1'b0;

        // 5: fragment of 5 bits discarded, then full 0x81
        cs_low();
        send_bits(8'h00, 5);
        cs_high();
        wait_cyc(6);
        chk("frag_rx_unchanged", host.spi_data_rx, 8'hFF);
        cs_low();
        rx_exp.push_back(8'h81);
        send_bits(8'h81, 8);
        cs_high();

        // 6: reset mid-byte, then a clean 0x5A
        host_write(8'hFF);
        cs_low();
        chk("pre_rst_miso", miso_pad, 1);
        host_write(8'h77);
        chk("pre_rst_valid_read", host.valid_read, 0);
        send_bits(8'h0F, 4);
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_dreq", host.spi_dreq, 0);
        chk("mid_rst_valid_read", host.valid_read, 1);
        chk("mid_rst_rx", host.spi_data_rx, 0);
        chk("mid_rst_miso", miso_pad, 0);
        wait_cyc(3);
        sys_rst_n = 1'b1;
        cs_high();
        cs_low();
        rx_exp.push_back(8'h5A);
        send_bits(8'h5A, 8);
        cs_high();

        wait_cyc(10);
        chk("rx_queue_drained", rx_exp.size(), 0);
        chk("miso_queue_drained", miso_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_single_clk_peripheral.md
Name: spi_single_clk_peripheral

Overview:
SPI mode-0 (CPOL=0, CPHA=0) peripheral, MSB first, fully in the sys_clk domain.
- CSN, SCK and MOSI pads are oversampled and synchronised; SCK edges are detected as single-cycle strobes.
- Each received byte is presented on spi_data_rx with a one-cycle spi_dreq pulse.
- A one-deep transmit holding register feeds MISO.
- Sits between the pad ring and a byte-oriented command/register block.

Parameters:
- BYTE_W, 8, bits per SPI word (shift length, data widths, bit-counter terminal value).

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- csn_pad  in  1  chip select from pad, active-low, asynchronous to sys_clk.
- sck_pad  in  1  SPI clock from pad, asynchronous.
- mosi_pad  in  1  controller-to-peripheral data, asynchronous.
- miso_pad  out  1  peripheral-to-controller data.
- spi_data_written  in  1  one-cycle strobe: load spi_data_to_send into the TX holding register.
- spi_data_to_send  in  BYTE_W  next byte to transmit.
- spi_data_rx  out  BYTE_W  last complete received byte; registered.
- spi_dreq  out  1  one-cycle pulse: spi_data_rx updated.
- valid_read  out  1  high when the TX holding register is empty and may be written.

Behaviour:
- Reset: all of the following are cleared. spi_data_rx=0, spi_dreq=0, valid_read=1, miso_pad=0, holding register=0, shift registers=0, bit counter=0, synchronisers to idle (csn=1, sck=0, mosi=0).
- Synchronisation:
  - csn, sck and mosi each pass through a 2-FF synchroniser plus one history FF.
  - sck_rise = sync & ~hist; sck_fall = ~sync & hist.
  - csn_fall is derived the same way.
- Operating range: SCK high and low phases must each be ≥ 4 sys_clk periods.
- While csn (synchronised) is high:
  - bit counter held at 0; RX shift register held at 0;
  - sck edges ignored; no spi_dreq;
  - miso_pad driven 0.
- csn_fall:
  - TX shift register loads from the holding register;
  - holding register marked empty (valid_read=1).
  - MISO then shows the MSB before the first SCK rise.
- sck_rise with CS active:
  - RX shift <= {RX shift[BYTE_W-2:0], mosi_sync}; bit counter +1.
  - When the counter reaches BYTE_W, on the next cycle: spi_data_rx <= assembled byte, spi_dreq=1 for exactly one cycle, counter <= 0.
  - On that same cycle the TX shift register reloads from the holding register and valid_read goes 1.
- sck_fall with CS active, and not the fall immediately following a reload: TX shift <= {TX shift[BYTE_W-2:0], 0}.
- miso_pad = TX shift MSB while CS is active.
- Latency: spi_data_rx and spi_dreq assert 4 sys_clk cycles after the 8th sck_pad rising edge (2 sync + 1 edge detect + 1 output register).
- Holding register:
  - spi_data_written loads spi_data_to_send and sets valid_read=0.
  - A write while valid_read=0 overwrites the pending byte (last write wins).
  - A write in the same cycle as a reload is captured after the reload. The reload takes the old content; the new byte is sent in the following word.
- Empty holding register at reload: the previous holding content (or 0 after reset) is retransmitted.
- CS deasserted mid-byte: partial byte discarded, no spi_dreq, counter cleared, spi_data_rx unchanged.
- Reset mid-transfer: everything returns to the reset values asynchronously.

Decomposition:
- Package: BYTE_W default, synchroniser depth (2), edge-detect typedef.
- Sub-module spi_pad_sync: parameterised 2-FF synchroniser with rise/fall strobe outputs, instantiated for csn, sck and mosi.

Test Plan:
1. Reset → spi_dreq=0, valid_read=1, spi_data_rx=0x00, miso_pad=0 while CS high.
2. Assert CS, clock 0xA5 MSB-first with SCK period 240 ns, sys_clk 20 ns → spi_data_rx=0xA5, spi_dreq high exactly 1 cycle, 4 cycles after the 8th SCK rise.
3. Write 0x3C via spi_data_written (valid_read→0), then assert CS and clock 8 bits → MISO sampled on rises = 0x3C; valid_read=1 after CS fall.
4. spi_dreq tied to spi_data_written with spi_data_to_send=0x00, MOSI held 1, continuous SCK for 3 bytes → three 0xFF receptions, three single-cycle pulses, MISO all zeros.
5. Deassert CS after 5 bits, then send a full 0x81 → no pulse for the fragment; spi_data_rx=0x81 after the full byte.
6. Pulse sys_rst_n low mid-byte → outputs immediately at reset values; next full byte 0x5A received correctly.
